// File: rtl/avalon_mm_32_to_16_write_adapter.sv
// Avalon-MM write bridge: one 32-bit slave write becomes up to two 16-bit
// master writes (low half first). Halves with an all-zero byteenable pair can
// be skipped. The master beat signals are registered; s_waitrequest and
// m_lock are combinational.
module avalon_mm_32_to_16_write_adapter #(
    parameter int ADDR_W          = 27,
    parameter int SKIP_EMPTY_HALF = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    // 32-bit slave side
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    input  logic [3:0]        s_byteenable,
    output logic              s_waitrequest,
    input  logic              s_lock,
    // 16-bit master side
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [15:0]       m_writedata,
    output logic [1:0]        m_byteenable,
    output logic              m_chipselect,
    input  logic              m_waitrequest,
    output logic              m_lock
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // With skipping disabled, every half is issued regardless of byteenable.
    localparam logic SKIP = (SKIP_EMPTY_HALF != 0);

    state_t            state_q, state_d;

    // Only the high half has to be remembered: the low beat is driven straight
    // from the slave inputs on the IDLE edge that latches the request.
    logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
    logic [15:0]       hi_data_q, hi_data_d;
    logic [1:0]        hi_be_q, hi_be_d;

    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_address_q, m_address_d;
    logic [15:0]       m_writedata_q, m_writedata_d;
    logic [1:0]        m_byteenable_q, m_byteenable_d;

    logic              need_lo_in;
    logic              need_hi_in;
    logic              need_hi_q;
    logic              beat_accepted;
    logic [ADDR_W-1:0] s_hi_address;

    assign need_lo_in    = !SKIP || (|s_byteenable[1:0]);
    assign need_hi_in    = !SKIP || (|s_byteenable[3:2]);
    assign need_hi_q     = !SKIP || (|hi_be_q);
    assign beat_accepted = m_write_q && !m_waitrequest;
    // Upper half sits two bytes above; wraps modulo 2^ADDR_W.
    assign s_hi_address  = s_address + ADDR_W'(2);

    // Next-state and next master-beat logic.
    always_comb begin
        state_d        = state_q;
        hi_addr_d      = hi_addr_q;
        hi_data_d      = hi_data_q;
        hi_be_d        = hi_be_q;
        m_write_d      = m_write_q;
        m_address_d    = m_address_q;
        m_writedata_d  = m_writedata_q;
        m_byteenable_d = m_byteenable_q;

        unique case (state_q)
            IDLE: begin
                if (s_write) begin
                    hi_addr_d = s_hi_address;
                    hi_data_d = s_writedata[31:16];
                    hi_be_d   = s_byteenable[3:2];
                    if (need_lo_in) begin
                        state_d        = LO;
                        m_write_d      = 1'b1;
                        m_address_d    = s_address;
                        m_writedata_d  = s_writedata[15:0];
                        m_byteenable_d = s_byteenable[1:0];
                    end else if (need_hi_in) begin
                        state_d        = HI;
                        m_write_d      = 1'b1;
                        m_address_d    = s_hi_address;
                        m_writedata_d  = s_writedata[31:16];
                        m_byteenable_d = s_byteenable[3:2];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LO: begin
                // The beat is held until accepted; the high beat only follows
                // if the slave is still requesting.
                if (beat_accepted) begin
                    if (need_hi_q && s_write) begin
                        state_d        = HI;
                        m_address_d    = hi_addr_q;
                        m_writedata_d  = hi_data_q;
                        m_byteenable_d = hi_be_q;
                    end else begin
                        state_d   = DONE;
                        m_write_d = 1'b0;
                    end
                end
            end
            HI: begin
                if (beat_accepted) begin
                    state_d   = DONE;
                    m_write_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                m_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending beat immediately.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            hi_addr_q      <= '0;
            hi_data_q      <= '0;
            hi_be_q        <= '0;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            m_byteenable_q <= '0;
        end else begin
            state_q        <= state_d;
            hi_addr_q      <= hi_addr_d;
            hi_data_q      <= hi_data_d;
            hi_be_q        <= hi_be_d;
            m_write_q      <= m_write_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            m_byteenable_q <= m_byteenable_d;
        end
    end

    assign s_waitrequest = s_write && (state_q != DONE);
    assign m_lock        = s_lock;
    assign m_write       = m_write_q;
    assign m_chipselect  = m_write_q;
    assign m_address     = m_address_q;
    assign m_writedata   = m_writedata_q;
    assign m_byteenable  = m_byteenable_q;

endmodule

// File: tb/tb_avalon_mm_32_to_16_write_adapter.sv
// Directed bench for the 32->16 Avalon-MM write adapter. Inputs change on the
// falling edge, outputs are sampled shortly after it.
module tb_avalon_mm_32_to_16_write_adapter;

    localparam int ADDR_W = 27;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] s_address;
    logic              s_write;
    logic [31:0]       s_writedata;
    logic [3:0]        s_byteenable;
    logic              s_waitrequest;
    logic              s_lock;
    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [15:0]       m_writedata;
    logic [1:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_waitrequest;
    logic              m_lock;

    always #5 clock = ~clock;

    avalon_mm_32_to_16_write_adapter #(
        .ADDR_W          (ADDR_W),
        .SKIP_EMPTY_HALF (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_byteenable  (s_byteenable),
        .s_waitrequest (s_waitrequest),
        .s_lock        (s_lock),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_waitrequest (m_waitrequest),
        .m_lock        (m_lock)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Beats observed as accepted during the last write, plus its latency.
    logic [ADDR_W-1:0] bt_addr [0:7];
    logic [15:0]       bt_data [0:7];
    logic [1:0]        bt_be   [0:7];
    int                bt_cyc  [0:7];
    int                nb;
    int                lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one slave write starting at a falling edge and watch 12 cycles.
    // The first stall_n cycles with m_write high are stalled and must show the
    // given beat; s_write is dropped at drop_cyc (or when accepted).
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int stall_n, input int drop_cyc,
                            input logic [ADDR_W-1:0] st_addr, input logic [15:0] st_data,
                            input logic [1:0] st_be);
        int stall_left;
        stall_left    = stall_n;
        nb            = 0;
        lat           = -1;
        s_address     = a;
        s_writedata   = d;
        s_byteenable  = be;
        s_write       = 1'b1;
        m_waitrequest = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == drop_cyc) s_write = 1'b0;
            m_waitrequest = m_write && (stall_left > 0);
            #1;
            if (m_waitrequest) begin
                check("stall_addr", 64'(m_address), 64'(st_addr));
                check("stall_data", 64'(m_writedata), 64'(st_data));
                check("stall_be", 64'(m_byteenable), 64'(st_be));
                stall_left--;
            end
            if (m_write && !m_waitrequest) begin
                if (nb < 8) begin
                    bt_addr[nb] = m_address;
                    bt_data[nb] = m_writedata;
                    bt_be[nb]   = m_byteenable;
                    bt_cyc[nb]  = cyc;
                end
                nb++;
            end
            if (s_write && !s_waitrequest) begin
                lat     = cyc;
                s_write = 1'b0;
            end
            @(negedge clock);
        end
        m_waitrequest = 1'b0;
        $display("write addr=0x%07h data=0x%08h be=%b stall=%0d beats=%0d latency=%0d",
                 a, d, be, stall_n, nb, lat);
    endtask

    initial begin
        reset_n       = 1'b0;
        s_address     = '0;
        s_write       = 1'b0;
        s_writedata   = '0;
        s_byteenable  = '0;
        s_lock        = 1'b0;
        m_waitrequest = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_m_write", 64'(m_write), 64'h0);
        check("rst_m_cs", 64'(m_chipselect), 64'h0);
        check("rst_m_addr", 64'(m_address), 64'h0);
        check("rst_m_data", 64'(m_writedata), 64'h0);
        check("rst_m_be", 64'(m_byteenable), 64'h0);
        check("rst_s_wait", 64'(s_waitrequest), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Full word: two beats, low half first, slave released in cycle 3.
        do_write(27'h100, 32'hDEADBEEF, 4'hF, 0, -1, '0, '0, '0);
        check("t1_nb", 64'(nb), 64'd2);
        check("t1_b0_addr", 64'(bt_addr[0]), 64'h100);
        check("t1_b0_data", 64'(bt_data[0]), 64'hBEEF);
        check("t1_b0_be", 64'(bt_be[0]), 64'h3);
        check("t1_b0_cyc", 64'(bt_cyc[0]), 64'd1);
        check("t1_b1_addr", 64'(bt_addr[1]), 64'h102);
        check("t1_b1_data", 64'(bt_data[1]), 64'hDEAD);
        check("t1_b1_be", 64'(bt_be[1]), 64'h3);
        check("t1_b1_cyc", 64'(bt_cyc[1]), 64'd2);
        check("t1_lat", 64'(lat), 64'd3);

        // Upper half only: low beat skipped.
        do_write(27'h200, 32'h12345678, 4'b1100, 0, -1, '0, '0, '0);
        check("t2_nb", 64'(nb), 64'd1);
        check("t2_b0_addr", 64'(bt_addr[0]), 64'h202);
        check("t2_b0_data", 64'(bt_data[0]), 64'h1234);
        check("t2_b0_be", 64'(bt_be[0]), 64'h3);
        check("t2_lat", 64'(lat), 64'd2);

        // Low beat stalled five cycles, then the high beat follows.
        do_write(27'h300, 32'hA5A55A5A, 4'hF, 5, -1, 27'h300, 16'h5A5A, 2'b11);
        check("t3_nb", 64'(nb), 64'd2);
        check("t3_b0_addr", 64'(bt_addr[0]), 64'h300);
        check("t3_b1_addr", 64'(bt_addr[1]), 64'h302);
        check("t3_b1_data", 64'(bt_data[1]), 64'hA5A5);
        check("t3_lat", 64'(lat), 64'd8);

        // High-beat address wraps at the top of the address space.
        do_write(27'h7FFFFFE, 32'hCAFEF00D, 4'hF, 0, -1, '0, '0, '0);
        check("t4_nb", 64'(nb), 64'd2);
        check("t4_b0_addr", 64'(bt_addr[0]), 64'h7FFFFFE);
        check("t4_b0_data", 64'(bt_data[0]), 64'hF00D);
        check("t4_b1_addr", 64'(bt_addr[1]), 64'h0);
        check("t4_b1_data", 64'(bt_data[1]), 64'hCAFE);

        // No enabled bytes: no master beat, released after one cycle.
        do_write(27'h180, 32'hFFFFFFFF, 4'h0, 0, -1, '0, '0, '0);
        check("t4b_nb", 64'(nb), 64'd0);
        check("t4b_lat", 64'(lat), 64'd1);

        // Partial enables in both halves.
        do_write(27'h040, 32'h11223344, 4'b0110, 0, -1, '0, '0, '0);
        check("pe_nb", 64'(nb), 64'd2);
        check("pe_b0_data", 64'(bt_data[0]), 64'h3344);
        check("pe_b0_be", 64'(bt_be[0]), 64'h2);
        check("pe_b1_addr", 64'(bt_addr[1]), 64'h042);
        check("pe_b1_data", 64'(bt_data[1]), 64'h1122);
        check("pe_b1_be", 64'(bt_be[1]), 64'h1);
        check("pe_lat", 64'(lat), 64'd3);

        // Reset asserted while the high beat is stalled.
        s_address     = 27'h600;
        s_writedata   = 32'h0BADF00D;
        s_byteenable  = 4'hF;
        s_write       = 1'b1;
        m_waitrequest = 1'b0;
        @(negedge clock);
        #1;
        check("t5_lo_write", 64'(m_write), 64'h1);
        @(negedge clock);
        #1;
        check("t5_hi_addr", 64'(m_address), 64'h602);
        check("t5_hi_data", 64'(m_writedata), 64'h0BAD);
        m_waitrequest = 1'b1;
        reset_n       = 1'b0;
        @(negedge clock);
        #1;
        check("t5_rst_write", 64'(m_write), 64'h0);
        check("t5_rst_cs", 64'(m_chipselect), 64'h0);
        check("t5_rst_addr", 64'(m_address), 64'h0);
        check("t5_rst_data", 64'(m_writedata), 64'h0);
        reset_n       = 1'b1;
        s_write       = 1'b0;
        m_waitrequest = 1'b0;
        @(negedge clock);
        do_write(27'h700, 32'h13572468, 4'hF, 0, -1, '0, '0, '0);
        check("t5_nb", 64'(nb), 64'd2);
        check("t5_b0_addr", 64'(bt_addr[0]), 64'h700);
        check("t5_b0_data", 64'(bt_data[0]), 64'h2468);
        check("t5_b1_data", 64'(bt_data[1]), 64'h1357);
        check("t5_lat", 64'(lat), 64'd3);

        // Lock is a straight combinational copy.
        s_lock = 1'b1;
        #1;
        check("lock_hi", 64'(m_lock), 64'h1);
        s_lock = 1'b0;
        #1;
        check("lock_lo", 64'(m_lock), 64'h0);
        @(negedge clock);

        // s_write dropped during the stalled low beat: low beat completes, no high beat.
        do_write(27'h500, 32'h87654321, 4'hF, 3, 2, 27'h500, 16'h4321, 2'b11);
        check("t6_nb", 64'(nb), 64'd1);
        check("t6_b0_addr", 64'(bt_addr[0]), 64'h500);
        check("t6_b0_data", 64'(bt_data[0]), 64'h4321);
        check("t6_b0_cyc", 64'(bt_cyc[0]), 64'd4);
        check("t6_idle_write", 64'(m_write), 64'h0);

        // Adapter is usable again afterwards.
        do_write(27'h520, 32'h0000ABCD, 4'b0011, 0, -1, '0, '0, '0);
        check("t6b_nb", 64'(nb), 64'd1);
        check("t6b_b0_addr", 64'(bt_addr[0]), 64'h520);
        check("t6b_b0_data", 64'(bt_data[0]), 64'hABCD);
        check("t6b_lat", 64'(lat), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
